// File: rtl/frame_reconstructor.sv
// Frame reconstructor: rebuilds a frame from a reference and a difference frame memory.
// Optional statistics (changed_count, stats_valid) enabled by defining FRAME_RECON_STATS_EN.
module frame_reconstructor #(
    parameter int         ADDR_W     = 19,
    parameter int         NUM_PIXELS = 307200,
    parameter int         RD_LAT     = 1,
    parameter logic [7:0] NEUTRAL    = 8'h80
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [23:0]       ref_q,
    input  logic [23:0]       diff_q,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data
`ifdef FRAME_RECON_STATS_EN
    ,
    output logic [ADDR_W-1:0] changed_count,
    output logic              stats_valid
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    function automatic logic [23:0] merge_pixel(input logic [23:0] r, input logic [23:0] d);
        logic [23:0] m;
        m = 24'h000000;
        for (int c = 0; c < 3; c++) begin
            m[8*c +: 8] = (d[8*c +: 8] == NEUTRAL) ? r[8*c +: 8] : d[8*c +: 8];
        end
        return m;
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic                busy_r;
    logic                done_r;
    logic                busy_s;
    logic                done_s;
    logic                issue_s;
    logic                pipe_empty_s;
    logic                tag_out_s;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic [RD_LAT-1:0]   pipe_vld_r;
    logic [ADDR_W-1:0]   pipe_addr_r [RD_LAT];
    logic                wr_en_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [23:0]         wr_data_r;

    assign issue_s      = (state_r == ST_RUN) && !pause;
    assign pipe_empty_s = (pipe_vld_r == {RD_LAT{1'b0}});
    assign tag_out_s    = pipe_vld_r[RD_LAT-1];

    // State register and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_RUN;
                else       state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (issue_s && (rd_addr_r == LAST_ADDR)) state_s = ST_DRAIN;
                else                                     state_s = ST_RUN;
            end
            // Leave once nothing is in flight; the last write happens in this same cycle
            ST_DRAIN: begin
                if (pipe_empty_s) state_s = ST_DONE;
                else              state_s = ST_DRAIN;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so busy/done come straight from flops
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            ST_RUN:   busy_s = 1'b1;
            ST_DRAIN: busy_s = 1'b1;
            ST_DONE:  done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Read address sweep; saturates at the last pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr_r <= {ADDR_W{1'b0}};
        end else if ((state_r == ST_IDLE) && start) begin
            rd_addr_r <= {ADDR_W{1'b0}};
        end else if (issue_s && (rd_addr_r != LAST_ADDR)) begin
            rd_addr_r <= rd_addr_r + ADDR_W'(1);
        end
    end

    // Valid/address shift pipeline matching the memory read latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld_r <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) pipe_addr_r[i] <= {ADDR_W{1'b0}};
        end else begin
            pipe_vld_r[0]  <= issue_s;
            pipe_addr_r[0] <= rd_addr_r;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_addr_r[i] <= pipe_addr_r[i-1];
            end
        end
    end

    // Write port: merge reference and difference data as it returns
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= 24'h000000;
        end else begin
            wr_en_r <= tag_out_s;
            if (tag_out_s) begin
                wr_addr_r <= pipe_addr_r[RD_LAT-1];
                wr_data_r <= merge_pixel(ref_q, diff_q);
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign rd_addr = rd_addr_r;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;

`ifdef FRAME_RECON_STATS_EN
    logic [ADDR_W-1:0] changed_count_r;
    logic              stats_valid_r;

    // Count pixels where any channel came from the difference frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            changed_count_r <= {ADDR_W{1'b0}};
            stats_valid_r   <= 1'b0;
        end else begin
            stats_valid_r <= done_s;
            if ((state_r == ST_IDLE) && start) begin
                changed_count_r <= {ADDR_W{1'b0}};
            end else if (tag_out_s && (diff_q != {3{NEUTRAL}})) begin
                changed_count_r <= changed_count_r + ADDR_W'(1);
            end
        end
    end

    assign changed_count = changed_count_r;
    assign stats_valid   = stats_valid_r;
`endif

endmodule
